// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-class execute/memory/writeback states for lw, sw, R-type, addi, beq and j.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] AluNone = 4'b0000;
    localparam logic [3:0] AluAdd  = 4'b0001;
    localparam logic [3:0] AluSub  = 4'b0010;
    localparam logic [3:0] AluAnd  = 4'b0011;
    localparam logic [3:0] AluOr   = 4'b0100;
    localparam logic [3:0] AluNor  = 4'b0101;
    localparam logic [3:0] AluSlt  = 4'b0110;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump
    } state_e;

    state_e     state_q;
    logic [3:0] r_alu;
    logic       r_legal;
    logic       op_legal;

    always_comb begin
        r_alu   = AluNone;
        r_legal = 1'b1;
        case (funct)
            6'b100000: r_alu = AluAdd;
            6'b100010: r_alu = AluSub;
            6'b100100: r_alu = AluAnd;
            6'b100101: r_alu = AluOr;
            6'b100111: r_alu = AluNor;
            6'b101010: r_alu = AluSlt;
            default:   r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OpRtype, OpLw, OpSw, OpAddi, OpBeq, OpJ: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    case (opcode)
                        OpRtype:    state_q <= StRExec;
                        OpLw, OpSw: state_q <= StMemAddr;
                        OpAddi:     state_q <= StIExec;
                        OpBeq:      state_q <= StBranch;
                        OpJ:        state_q <= StJump;
                        default:    state_q <= StFetch;
                    endcase
                end
                StMemAddr: state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
                StMemRd:   state_q <= StMemWb;
                StRExec:   state_q <= r_legal ? StRWb : StFetch;
                StIExec:   state_q <= StIWb;
                default:   state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        alu_ctrl   = AluNone;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_rd    = 1'b1;
                ir_we     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = AluAdd;
                pc_en     = 1'b1;
            end
            StDecode: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b  = 2'b11;
                alu_ctrl   = AluAdd;
                illegal    = ~op_legal;
                instr_done = ~op_legal;
            end
            StMemAddr, StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = AluAdd;
            end
            StMemRd: mem_rd = 1'b1;
            StMemWb: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_we     = 1'b1;
                instr_done = 1'b1;
            end
            StRExec: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = r_alu;
                illegal    = ~r_legal;
                instr_done = ~r_legal;
            end
            StRWb: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StIWb: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = AluSub;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every side effect of an interrupted instruction.
        if (rst) begin
            ir_we      = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            pc_en      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk (posedge) and rst.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opcode  input  6  instr[31:26], stable from DECODE through the end of the instruction.
REQ-005 funct  input  6  instr[5:0], used only for R-type.
REQ-006 zero  input  1  ALU zero flag, sampled combinationally in BRANCH.
REQ-007 alu_ctrl  output  4  ALU op: 0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 slt, 0000 none.
REQ-008 alu_src_a  output  1  0=PC, 1=register A.
REQ-009 alu_src_b  output  2  00=register B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 ir_we, mem_rd, mem_we, reg_we  outputs  1 each  IR load, memory read, memory write, register-file write.
REQ-011 reg_dst  output  1  write-register select: 0=rt, 1=rd.
REQ-012 mem_to_reg  output  1  write-data select: 0=ALUOut, 1=MDR.
REQ-013 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-014 pc_en  output  1  PC load enable.
REQ-015 instr_done  output  1  one-cycle pulse in the last state of every instruction.
REQ-016 illegal  output  1  one-cycle pulse on an unsupported opcode/funct.

Function
REQ-017 The FSM SHALL be Moore, with a registered state; outputs SHALL decode from state, except: pc_en in BRANCH uses zero; alu_ctrl in R_EXEC uses funct.
REQ-018 States SHALL be: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-019 FETCH: mem_rd=1, ir_we=1, alu_src_a=0, alu_src_b=01, alu_ctrl=0001, pc_src=00, pc_en=1; next DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0001 (branch target precompute).
REQ-021 DECODE next state: 000000->R_EXEC, 100011/101011->MEM_ADDR, 001000->I_EXEC, 000100->BRANCH, 000010->JUMP.
REQ-022 DECODE, any other opcode: next FETCH; illegal=1 and instr_done=1 in DECODE.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=0001; next MEM_RD if opcode=100011, else MEM_WR.
REQ-024 MEM_RD: mem_rd=1; next MEM_WB.
REQ-025 MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1; next FETCH.
REQ-026 MEM_WR: mem_we=1, instr_done=1; next FETCH.
REQ-027 R_EXEC: alu_src_a=1, alu_src_b=00; funct 100000->0001, 100010->0010, 100100->0011, 100101->0100, 100111->0101, 101010->0110.
REQ-028 R_EXEC, unsupported funct: alu_ctrl=0000, illegal=1, instr_done=1; next FETCH with no R_WB write.
REQ-029 R_WB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-030 I_EXEC (addi): alu_src_a=1, alu_src_b=10, alu_ctrl=0001; next I_WB.
REQ-031 I_WB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
REQ-032 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=0010, pc_src=01, pc_en=zero, instr_done=1; next FETCH.
REQ-033 JUMP: pc_src=10, pc_en=1, instr_done=1; next FETCH.
REQ-034 Outputs not listed for a state SHALL be 0 (alu_ctrl=0000, pc_src=00, alu_src_b=00).
REQ-035 Instruction latency SHALL be: lw 5 cycles; sw/R/addi 4; beq/j 3; illegal 2 (decode) or 3 (funct).
REQ-036 mem_rd and mem_we SHALL never be asserted in the same cycle.
REQ-037 reg_we and mem_we SHALL never be asserted in the same cycle.

Reset
REQ-038 With rst=1 at a clock edge, state SHALL become FETCH regardless of current state, including mid-instruction.
REQ-039 While rst=1, all write enables (ir_we, mem_we, reg_we, pc_en), instr_done and illegal SHALL be forced to 0.
REQ-040 An interrupted instruction SHALL produce no further writes after reset; the first cycle after rst deasserts is FETCH.

Verification
REQ-041 opcode=000000, funct=100010 from reset -> FETCH, DECODE, R_EXEC (alu_ctrl=0010), R_WB (reg_we=1, reg_dst=1); instr_done on cycle 4.
REQ-042 opcode=100011 -> 5 states, MEM_ADDR alu_src_b=10; MEM_WB reg_we=1, mem_to_reg=1; no mem_we at any point.
REQ-043 opcode=000100 with zero=1 -> pc_en=1, pc_src=01 in cycle 3; repeat with zero=0 -> pc_en=0 in cycle 3; both return to FETCH.
REQ-044 opcode=111111 -> illegal=1 and instr_done=1 in DECODE, then FETCH; opcode=000000, funct=000001 -> illegal in R_EXEC and reg_we never 1.
REQ-045 opcode=100011 with rst=1 during MEM_RD -> next cycle FETCH, MEM_WB never entered, reg_we stays 0.
REQ-046 Random opcode/funct stream for 10k cycles -> assertions on REQ-036/037; instr_done count matches instructions issued.
